pc_next_unit: RTL and testbench

// - Program-counter stage of the pipelined core: holds the fetch PC and issues it to instruction memory.
// - Normal advance is PC+4. Stall holds the PC.
// - Branches resolved downstream redirect the PC to B/CBZ-style targets: sext(offset)<<2 added to the branch PC.
// - Mispredicted branches flush the younger stages. An optional BTB predicts taken branches at fetch.

---
 rtl/pc_next_unit.sv | 110 +++++++++++
 tb/tb_pc_next_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// Fetch PC register: PC+4 advance, stall hold, branch redirect with flush and mispredict counter.
// Optional direct-mapped BTB predictor compiled in when PC_BTB_EN is defined.
module pc_next_unit #(
  parameter int                 ADDR_W       = 64,
  parameter int                 COND_OFS_W   = 19,
  parameter int                 UNCOND_OFS_W = 26,
  parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
  parameter int                 BTB_DEPTH    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic              pred_taken,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic              br_pred_taken,
  input  logic              uncond_br,
  input  logic [31:0]       br_instr,
  input  logic [ADDR_W-1:0] br_pc,
  output logic              flush,
  output logic [31:0]       mispredict_cnt
);

  logic [ADDR_W-1:0] ofs;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] fall;
  logic [ADDR_W-1:0] pred_tgt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              redirect;

  // Conditional offset sits at [23:5]; unconditional at [25:0]
  always_comb begin
    ofs = '0;
    if (uncond_br)
      ofs = {{(ADDR_W-UNCOND_OFS_W){br_instr[UNCOND_OFS_W-1]}}, br_instr[UNCOND_OFS_W-1:0]};
    else
      ofs = {{(ADDR_W-COND_OFS_W){br_instr[COND_OFS_W+4]}}, br_instr[COND_OFS_W+4:5]};
  end

  assign tgt      = br_pc + (ofs << 2);
  assign fall     = br_pc + ADDR_W'(4);
  assign redirect = br_valid & (br_taken != br_pred_taken);
  assign flush    = redirect & ~reset;

  always_comb begin
    pc_nxt = pc + ADDR_W'(4);
    if (redirect)
      pc_nxt = br_taken ? tgt : fall;
    else if (stall)
      pc_nxt = pc;
    else if (pred_taken)
      pc_nxt = pred_tgt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      mispredict_cnt <= '0;
    end else begin
      pc <= pc_nxt;
      if (redirect && mispredict_cnt != 32'hFFFF_FFFF)
        mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

`ifdef PC_BTB_EN
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - 2;

  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
  logic [ADDR_W-1:0]    btb_tgt [BTB_DEPTH];
  logic [IDX_W-1:0]     rd_idx;
  logic [IDX_W-1:0]     wr_idx;
  logic                 unused_ok;

  assign rd_idx     = pc[2 +: IDX_W];
  assign wr_idx     = br_pc[2 +: IDX_W];
  assign pred_taken = btb_valid[rd_idx] && (btb_tag[rd_idx] == pc[ADDR_W-1:2]);
  assign pred_tgt   = btb_tgt[rd_idx];
  assign unused_ok  = ^br_instr[31:26];

  // Writes land at the clock edge, so a same-cycle lookup sees the old entry
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid <= '0;
    end else if (br_valid) begin
      if (br_taken)
        btb_valid[wr_idx] <= 1'b1;
      else if (btb_tag[wr_idx] == br_pc[ADDR_W-1:2])
        btb_valid[wr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && br_valid && br_taken) begin
      btb_tag[wr_idx] <= br_pc[ADDR_W-1:2];
      btb_tgt[wr_idx] <= tgt;
    end
  end
`else
  logic unused_ok;

  assign pred_taken = 1'b0;
  assign pred_tgt   = '0;
  assign unused_ok  = ^{br_instr[31:26], 32'(BTB_DEPTH)};
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: reset, advance, stall, branch redirects, wrap-around, optional BTB.
module tb_pc_next_unit;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          reset, stall;
  logic          br_valid, br_taken, br_pred_taken, uncond_br;
  logic [31:0]   br_instr;
  logic [AW-1:0] br_pc;
  logic [AW-1:0] pc, pc_w;
  logic          pred_taken, pred_taken_w, flush, flush_w;
  logic [31:0]   mispredict_cnt, cnt_w;

  int cmp = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pc_next_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .pc(pc), .pred_taken(pred_taken),
    .br_valid(br_valid), .br_taken(br_taken), .br_pred_taken(br_pred_taken),
    .uncond_br(uncond_br), .br_instr(br_instr), .br_pc(br_pc),
    .flush(flush), .mispredict_cnt(mispredict_cnt)
  );

  pc_next_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall), .pc(pc_w), .pred_taken(pred_taken_w),
    .br_valid(br_valid), .br_taken(br_taken), .br_pred_taken(br_pred_taken),
    .uncond_br(uncond_br), .br_instr(br_instr), .br_pc(br_pc),
    .flush(flush_w), .mispredict_cnt(cnt_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br_valid = 1'b0; br_taken = 1'b0; br_pred_taken = 1'b0;
    uncond_br = 1'b0; br_instr = 32'h0; br_pc = '0;
  endtask

  task automatic branch(input logic taken, input logic pred, input logic uc,
                        input logic [31:0] instr, input logic [AW-1:0] bpc);
    br_valid = 1'b1; br_taken = taken; br_pred_taken = pred;
    uncond_br = uc; br_instr = instr; br_pc = bpc;
  endtask

  task automatic test_reset();
    logic [AW-1:0] exp;
    reset = 1'b1; stall = 1'b0;
    branch(1'b1, 1'b0, 1'b0, 32'h60, 64'h100);
    step(); step();
    cmp++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got %b exp 0", flush); end
    cmp++; if (pc !== 64'h0) begin bad++; $display("FAIL reset_pc got %h exp 0", pc); end
    cmp++; if (mispredict_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got %0d exp 0", mispredict_cnt); end
    cmp++; if (pc_w !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL reset_pc_wrap got %h exp fffffffffffffffc", pc_w); end
    reset = 1'b0; idle();
    for (int i = 1; i <= 3; i++) begin
      step();
      exp = 64'(i * 4);
      cmp++; if (pc !== exp) begin bad++; $display("FAIL idle_pc%0d got %h exp %h", i, pc, exp); end
      cmp++; if (flush !== 1'b0) begin bad++; $display("FAIL idle_flush%0d got %b exp 0", i, flush); end
      if (i == 1) begin
        cmp++; if (pc_w !== 64'h0) begin bad++; $display("FAIL wrap_pc got %h exp 0", pc_w); end
      end
    end
    cmp++; if (mispredict_cnt !== 32'd0) begin bad++; $display("FAIL idle_cnt got %0d exp 0", mispredict_cnt); end
    cmp++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL idle_pred got %b exp 0", pred_taken); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 20 && pc !== 64'h20; i++) step();
    cmp++; if (pc !== 64'h20) begin bad++; $display("FAIL reach_20 got %h exp 20", pc); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      cmp++; if (pc !== 64'h20) begin bad++; $display("FAIL stall_pc%0d got %h exp 20", i, pc); end
    end
    stall = 1'b0;
    step();
    cmp++; if (pc !== 64'h24) begin bad++; $display("FAIL unstall_pc got %h exp 24", pc); end
  endtask

  task automatic test_cond_branch();
    branch(1'b1, 1'b0, 1'b0, {8'hA5, 19'd3, 5'h1F}, 64'h100);
    #1;
    cmp++; if (flush !== 1'b1) begin bad++; $display("FAIL cond_flush got %b exp 1", flush); end
    step();
    cmp++; if (pc !== 64'h10C) begin bad++; $display("FAIL cond_pc got %h exp 10c", pc); end
    cmp++; if (mispredict_cnt !== 32'd1) begin bad++; $display("FAIL cond_cnt got %0d exp 1", mispredict_cnt); end
    idle();
    #1;
    cmp++; if (flush !== 1'b0) begin bad++; $display("FAIL cond_flush_off got %b exp 0", flush); end
  endtask

  task automatic test_uncond_branch();
    branch(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 64'h200);
    step();
    cmp++; if (pc !== 64'h1FC) begin bad++; $display("FAIL uncond_pc got %h exp 1fc", pc); end
    cmp++; if (mispredict_cnt !== 32'd2) begin bad++; $display("FAIL uncond_cnt got %0d exp 2", mispredict_cnt); end
    idle();
  endtask

  task automatic test_cond_negative();
    branch(1'b1, 1'b0, 1'b0, {8'hFF, 19'h7FFFE, 5'h1F}, 64'h1000);
    step();
    cmp++; if (pc !== 64'hFF8) begin bad++; $display("FAIL condneg_pc got %h exp ff8", pc); end
    idle();
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1;
    branch(1'b1, 1'b0, 1'b0, {8'h00, 19'd3, 5'h00}, 64'h100);
    step();
    cmp++; if (pc !== 64'h10C) begin bad++; $display("FAIL stallredir_pc got %h exp 10c", pc); end
    cmp++; if (mispredict_cnt !== 32'd4) begin bad++; $display("FAIL stallredir_cnt got %0d exp 4", mispredict_cnt); end
    idle();
    step();
    cmp++; if (pc !== 64'h10C) begin bad++; $display("FAIL stallhold_pc got %h exp 10c", pc); end
    stall = 1'b0;
  endtask

  task automatic test_not_taken_redirect();
    branch(1'b0, 1'b1, 1'b0, {8'h00, 19'd7, 5'h00}, 64'h300);
    #1;
    cmp++; if (flush !== 1'b1) begin bad++; $display("FAIL nt_flush got %b exp 1", flush); end
    step();
    cmp++; if (pc !== 64'h304) begin bad++; $display("FAIL nt_pc got %h exp 304", pc); end
    cmp++; if (mispredict_cnt !== 32'd5) begin bad++; $display("FAIL nt_cnt got %0d exp 5", mispredict_cnt); end
    idle();
  endtask

  task automatic test_no_redirect();
    br_valid = 1'b0; br_taken = 1'b1; br_pred_taken = 1'b0; br_pc = 64'h500; br_instr = 32'h40;
    #1;
    cmp++; if (flush !== 1'b0) begin bad++; $display("FAIL invalid_flush got %b exp 0", flush); end
    step();
    cmp++; if (pc !== 64'h308) begin bad++; $display("FAIL invalid_pc got %h exp 308", pc); end
    branch(1'b1, 1'b1, 1'b0, {8'h00, 19'd5, 5'h00}, 64'h400);
    #1;
    cmp++; if (flush !== 1'b0) begin bad++; $display("FAIL agree_flush got %b exp 0", flush); end
    step();
    cmp++; if (pc !== 64'h30C) begin bad++; $display("FAIL agree_pc got %h exp 30c", pc); end
    cmp++; if (mispredict_cnt !== 32'd5) begin bad++; $display("FAIL agree_cnt got %0d exp 5", mispredict_cnt); end
    idle();
  endtask

`ifdef PC_BTB_EN
  task automatic test_btb();
    reset = 1'b1; idle(); step(); reset = 1'b0;
    branch(1'b1, 1'b0, 1'b0, {8'h00, 19'h10, 5'h00}, 64'h40);
    #1;
    cmp++; if (flush !== 1'b1) begin bad++; $display("FAIL btb_train_flush got %b exp 1", flush); end
    step();
    cmp++; if (pc !== 64'h80) begin bad++; $display("FAIL btb_train_pc got %h exp 80", pc); end
    branch(1'b1, 1'b0, 1'b0, {8'h00, 19'd1, 5'h00}, 64'h3C);
    step();
    idle();
    #1;
    cmp++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL btb_hit got %b exp 1", pred_taken); end
    step();
    cmp++; if (pc !== 64'h80) begin bad++; $display("FAIL btb_pred_pc got %h exp 80", pc); end
    branch(1'b1, 1'b0, 1'b0, {8'h00, 19'd1, 5'h00}, 64'h3C);
    step();
    branch(1'b0, 1'b1, 1'b0, {8'h00, 19'h10, 5'h00}, 64'h40);
    #1;
    cmp++; if (flush !== 1'b1) begin bad++; $display("FAIL btb_nt_flush got %b exp 1", flush); end
    step();
    cmp++; if (pc !== 64'h44) begin bad++; $display("FAIL btb_nt_pc got %h exp 44", pc); end
    cmp++; if (mispredict_cnt !== 32'd4) begin bad++; $display("FAIL btb_nt_cnt got %0d exp 4", mispredict_cnt); end
    branch(1'b1, 1'b0, 1'b0, {8'h00, 19'd1, 5'h00}, 64'h3C);
    step();
    idle();
    #1;
    cmp++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL btb_inval got %b exp 0", pred_taken); end
    step();
    cmp++; if (pc !== 64'h44) begin bad++; $display("FAIL btb_inval_pc got %h exp 44", pc); end
  endtask
`endif

  initial begin
    reset = 1'b1; stall = 1'b0; idle();
    test_reset();
    test_stall();
    test_cond_branch();
    test_uncond_branch();
    test_cond_negative();
    test_stall_redirect();
    test_not_taken_redirect();
    test_no_redirect();
`ifdef PC_BTB_EN
    test_btb();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
